// File: rtl/imm_ext.sv
// imm_ext: registered 16->32 bit immediate extender with valid flag
module imm_ext #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] imm,
    input  logic [1:0]  EOp,
    output logic [31:0] ext,
    output logic        out_valid
);
    logic [31:0] f;
    // extension function selected by EOp: sign, zero, load-upper, branch offset
    always_comb
        f = EOp == 2'b00 ? {{16{imm[15]}}, imm} :
            EOp == 2'b01 ? {16'h0000, imm} :
            EOp == 2'b10 ? {imm, 16'h0000} :
                           {{14{imm[15]}}, imm, 2'b00};
    // capture result on accepted input, hold otherwise; valid tracks in_valid
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ext       <= RESET_VAL;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) ext <= f;
        end
endmodule

// File: tb/tb_imm_ext.sv
// tb_imm_ext: directed and random checks of imm_ext against an arithmetic model
module tb_imm_ext;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] imm = '0;
    logic [1:0]  EOp = '0;
    logic [31:0] ext;
    logic        out_valid;
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_ext = 32'h0;
    logic        exp_v = 1'b0;

    imm_ext dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .imm(imm), .EOp(EOp), .ext(ext), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [15:0] i, input logic [1:0] e);
        longint s;
        longint u;
        longint r;
        s = (i >= 16'h8000) ? longint'(i) - 65536 : longint'(i);
        u = longint'(i);
        r = (e == 2'd0) ? s : (e == 2'd1) ? u : (e == 2'd2) ? u * 65536 : s * 4;
        return r[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input logic v, input logic [15:0] i, input logic [1:0] e);
        in_valid = v;
        imm = i;
        EOp = e;
        @(posedge clk);
        if (v) exp_ext = model(i, e);
        exp_v = v;
        #1;
        chk("ext", ext, exp_ext);
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ext", ext, 32'h0);
        chk("rst_vld", {31'b0, out_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 16'h1234, 2'd1);
        chk("rel_ext", ext, 32'h0);

        cyc(1'b1, 16'h800F, 2'd0); chk("n_sx", ext, 32'hFFFF800F);
        cyc(1'b1, 16'h800F, 2'd1); chk("n_zx", ext, 32'h0000800F);
        cyc(1'b1, 16'h800F, 2'd2); chk("n_lu", ext, 32'h800F0000);
        cyc(1'b1, 16'h800F, 2'd3); chk("n_br", ext, 32'hFFFE003C);
        cyc(1'b1, 16'h7FFF, 2'd0); chk("p_sx", ext, 32'h00007FFF);
        cyc(1'b1, 16'h7FFF, 2'd1); chk("p_zx", ext, 32'h00007FFF);
        cyc(1'b1, 16'h7FFF, 2'd2); chk("p_lu", ext, 32'h7FFF0000);
        cyc(1'b1, 16'h7FFF, 2'd3); chk("p_br", ext, 32'h0001FFFC);

        cyc(1'b0, 16'hAAAA, 2'd0);
        cyc(1'b0, 16'h5555, 2'd2);
        cyc(1'b0, 16'hFFFF, 2'd3);
        chk("hold", ext, 32'h0001FFFC);

        cyc(1'b1, 16'h8001, 2'd0);
        chk("pre_rst_vld", {31'b0, out_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ext", ext, 32'h0);
        chk("arst_vld", {31'b0, out_valid}, 32'h0);
        exp_ext = 32'h0;
        exp_v = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_drop_ext", ext, 32'h0);
        chk("rst_drop_vld", {31'b0, out_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        cyc(1'b1, 16'h0001, 2'd0); chk("b2b0", ext, 32'h00000001);
        cyc(1'b1, 16'h0001, 2'd1); chk("b2b1", ext, 32'h00000001);
        cyc(1'b1, 16'h0001, 2'd2); chk("b2b2", ext, 32'h00010000);
        cyc(1'b1, 16'h0001, 2'd3); chk("b2b3", ext, 32'h00000004);

        for (int k = 0; k < 300; k++)
            cyc(1'($urandom_range(0, 3) != 0), 16'($urandom), 2'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
